// File: rtl/simon_ctrl_if.sv
// Bus between the Simon control FSM and its surroundings: user inputs, pattern memory and LEDs.
// The slave modport is the controller's view; the master modport is the surrounding top level's view.
interface simon_ctrl_if #(
    parameter int AW = 6
);
    logic          step;
    logic          level;
    logic [3:0]    pattern;
    logic [3:0]    mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wdata;
    logic          mem_we;
    logic [2:0]    mode_leds;
    logic [3:0]    pattern_leds;

    modport slave (
        input  step, level, pattern, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mode_leds, pattern_leds
    );

    modport master (
        output step, level, pattern, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mode_leds, pattern_leds
    );
endinterface

// File: rtl/simon_ctrl.sv
// Simon game control FSM: Input -> Playback -> Repeat -> (Input | Done), owning count/idx and the memory strobe.
// Optional macro SIMON_AUTOPLAY_EN: playback auto-advances every PLAY_TICKS cycles instead of on step.
module simon_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
`ifdef SIMON_AUTOPLAY_EN
    ,
    parameter int PLAY_TICKS = 25000000
`endif
) (
    input  logic         clk,
    input  logic         rst,
    simon_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_INPUT,
        S_PLAYBACK,
        S_REPEAT,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [AW:0]   count_q;
    logic [AW-1:0] idx_q;

    logic legal;
    logic at_last;
    logic match;
    logic play_adv;

    assign legal   = bus.level ? (bus.pattern != 4'd0) : $onehot(bus.pattern);
    assign at_last = ({1'b0, idx_q} == (count_q - (AW+1)'(1)));
    assign match   = (bus.pattern == bus.mem_rdata);

`ifdef SIMON_AUTOPLAY_EN
    localparam int TW = (PLAY_TICKS > 1) ? $clog2(PLAY_TICKS) : 1;

    logic [TW-1:0] tick_q;

    assign play_adv = (tick_q == TW'(PLAY_TICKS - 1));

    // Held at zero outside PLAYBACK, so every entry starts a fresh interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else if ((state_q != S_PLAYBACK) || play_adv) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end
`else
    assign play_adv = bus.step;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INPUT;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_INPUT: begin
                    if (bus.step && legal) begin
                        count_q <= count_q + 1'b1;
                        idx_q   <= '0;
                        state_q <= S_PLAYBACK;
                    end
                end
                S_PLAYBACK: begin
                    if (play_adv) begin
                        if (at_last) begin
                            idx_q   <= '0;
                            state_q <= S_REPEAT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_REPEAT: begin
                    if (bus.step) begin
                        if (!match) begin
                            idx_q   <= '0;
                            state_q <= S_DONE;
                        end else if (at_last) begin
                            idx_q   <= '0;
                            state_q <= (count_q == (AW+1)'(DEPTH)) ? S_DONE : S_INPUT;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Endless replay of the final sequence until reset.
                    if (bus.step) begin
                        idx_q <= at_last ? '0 : (idx_q + 1'b1);
                    end
                end
                default: begin
                    state_q <= S_INPUT;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_wdata    = bus.pattern;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = idx_q;
        bus.mode_leds    = 3'b001;
        bus.pattern_leds = bus.pattern;
        case (state_q)
            S_INPUT: begin
                // count never reaches DEPTH while in INPUT, so its low bits are a valid address.
                bus.mem_addr = count_q[AW-1:0];
                bus.mem_we   = bus.step && legal && !rst;
            end
            S_PLAYBACK: begin
                bus.mode_leds    = 3'b010;
                bus.pattern_leds = bus.mem_rdata;
            end
            S_REPEAT: begin
                bus.mode_leds = 3'b100;
            end
            S_DONE: begin
                bus.mode_leds    = 3'b111;
                bus.pattern_leds = bus.mem_rdata;
            end
            default: begin
                bus.mode_leds = 3'b001;
            end
        endcase
    end

endmodule

// File: tb/tb_simon_ctrl.sv
// Randomized bench for simon_ctrl against a queue-based game model; the pattern memory lives in the bench.
`timescale 1ns/1ps
module tb_simon_ctrl;
    localparam int DEPTH      = 4;
    localparam int AW         = 2;
    localparam int PLAY_TICKS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    simon_ctrl_if #(.AW(AW)) bus ();

    logic [3:0] mem [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    simon_ctrl #(
        .DEPTH(DEPTH),
        .AW(AW)
`ifdef SIMON_AUTOPLAY_EN
        ,
        .PLAY_TICKS(PLAY_TICKS)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Game model: 0 input, 1 playback, 2 repeat, 3 done; m_seq is the stored sequence.
    int         m_mode;
    int         m_cur;
    logic [3:0] m_seq [$];

    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [3:0]    obs_wdata;
    logic          exp_we;
    logic [AW-1:0] exp_addr_pre;

    function automatic bit is_legal(input logic lvl, input logic [3:0] p);
        return lvl ? (p != 4'd0) : (p == 4'd1 || p == 4'd2 || p == 4'd4 || p == 4'd8);
    endfunction

    function automatic logic [2:0] exp_mode();
        case (m_mode)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        return (m_mode == 0) ? AW'(m_seq.size()) : AW'(m_cur);
    endfunction

    function automatic logic [3:0] exp_pleds(input logic [3:0] p);
        return (m_mode == 1 || m_mode == 3) ? m_seq[m_cur] : p;
    endfunction

    function automatic void model_reset();
        m_seq.delete();
        m_mode = 0;
        m_cur  = 0;
    endfunction

    function automatic void model_step(input logic [3:0] p, input logic lvl);
        int last;
        last = m_seq.size() - 1;
        case (m_mode)
            0: if (is_legal(lvl, p)) begin
                m_seq.push_back(p);
                m_mode = 1;
                m_cur  = 0;
            end
            1: if (m_cur == last) begin
                m_mode = 2;
                m_cur  = 0;
            end else m_cur++;
            2: if (p != m_seq[m_cur]) begin
                m_mode = 3;
                m_cur  = 0;
            end else if (m_cur == last) begin
                m_mode = (m_seq.size() == DEPTH) ? 3 : 0;
                m_cur  = 0;
            end else m_cur++;
            default: m_cur = (m_cur == last) ? 0 : m_cur + 1;
        endcase
    endfunction

    task automatic press(input logic [3:0] p);
        @(negedge clk);
        bus.pattern = p;
        bus.step    = 1'b1;
        #1;
        obs_we       = bus.mem_we;
        obs_addr     = bus.mem_addr;
        obs_wdata    = bus.mem_wdata;
        exp_we       = (m_mode == 0) && is_legal(bus.level, p);
        exp_addr_pre = exp_addr();
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        model_step(p, bus.level);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.step    = 1'b1;
        bus.pattern = 4'b0001;
        bus.level   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.mem_we); end
        n_tests++; if (bus.mode_leds !== 3'b001) begin n_fail++; $display("FAIL reset_mode: got %b expected 001", bus.mode_leds); end
        n_tests++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
        @(negedge clk);
        rst      = 1'b0;
        bus.step = 1'b0;
        model_reset();
        #1;
        n_tests++; if (bus.pattern_leds !== 4'b0001) begin n_fail++; $display("FAIL reset_pleds: got %b expected 0001", bus.pattern_leds); end
        n_tests++; if (bus.mode_leds !== 3'b001) begin n_fail++; $display("FAIL reset_release_mode: got %b expected 001", bus.mode_leds); end
    endtask

    task automatic test_input_legality();
        bus.level = 1'b0;
        press(4'b0011);
        n_tests++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL illegal_we: got %b expected 0", obs_we); end
        n_tests++; if (bus.mode_leds !== 3'b001) begin n_fail++; $display("FAIL illegal_mode: got %b expected 001", bus.mode_leds); end
        press(4'b0100);
        n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL legal_we: got %b expected 1", obs_we); end
        n_tests++; if (obs_addr !== '0) begin n_fail++; $display("FAIL legal_addr: got %0d expected 0", obs_addr); end
        n_tests++; if (obs_wdata !== 4'b0100) begin n_fail++; $display("FAIL legal_wdata: got %b expected 0100", obs_wdata); end
        n_tests++; if (bus.mode_leds !== 3'b010) begin n_fail++; $display("FAIL legal_mode: got %b expected 010", bus.mode_leds); end
        n_tests++; if (bus.pattern_leds !== 4'b0100) begin n_fail++; $display("FAIL legal_pleds: got %b expected 0100", bus.pattern_leds); end
    endtask

    task automatic test_playback_repeat();
        press(4'b0000);
        n_tests++; if (bus.mode_leds !== 3'b100) begin n_fail++; $display("FAIL play_to_repeat: got %b expected 100", bus.mode_leds); end
        press(4'b0100);
        n_tests++; if (bus.mode_leds !== 3'b001) begin n_fail++; $display("FAIL repeat_to_input: got %b expected 001", bus.mode_leds); end
        n_tests++; if (bus.mem_addr !== AW'(1)) begin n_fail++; $display("FAIL input_addr1: got %0d expected 1", bus.mem_addr); end
        press(4'b0010);
        n_tests++; if (bus.pattern_leds !== 4'b0100) begin n_fail++; $display("FAIL play_idx0: got %b expected 0100", bus.pattern_leds); end
        press(4'b0000);
        n_tests++; if (bus.pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL play_idx1: got %b expected 0010", bus.pattern_leds); end
        press(4'b0000);
        n_tests++; if (bus.mode_leds !== 3'b100) begin n_fail++; $display("FAIL play2_to_repeat: got %b expected 100", bus.mode_leds); end
    endtask

    task automatic test_lose();
        int extra;
        press(4'b1000);
        n_tests++; if (bus.mode_leds !== 3'b111) begin n_fail++; $display("FAIL lose_mode: got %b expected 111", bus.mode_leds); end
        n_tests++; if (bus.pattern_leds !== 4'b0100) begin n_fail++; $display("FAIL lose_pleds0: got %b expected 0100", bus.pattern_leds); end
        press(4'b0000);
        n_tests++; if (bus.pattern_leds !== 4'b0010) begin n_fail++; $display("FAIL done_pleds1: got %b expected 0010", bus.pattern_leds); end
        press(4'b0000);
        n_tests++; if (bus.pattern_leds !== 4'b0100) begin n_fail++; $display("FAIL done_wrap: got %b expected 0100", bus.pattern_leds); end
        extra = $urandom_range(1, 5);
        for (int i = 0; i < extra; i++) begin
            press(4'($urandom_range(0, 15)));
            n_tests++; if (bus.mode_leds !== 3'b111 || bus.pattern_leds !== exp_pleds(bus.pattern)) begin
                n_fail++; $display("FAIL done_stays: got mode %b leds %b expected 111 %b", bus.mode_leds, bus.pattern_leds, exp_pleds(bus.pattern));
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (bus.mode_leds !== 3'b001 || bus.mem_addr !== '0) begin
            n_fail++; $display("FAIL async_reset: got mode %b addr %0d expected 001 0", bus.mode_leds, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        bus.level = 1'b0;
        @(negedge clk);
        bus.pattern = 4'b1000;
        bus.step    = 1'b1;
        #1;
        n_tests++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we0: got %b expected 1", bus.mem_we); end
        @(posedge clk);
        model_step(4'b1000, 1'b0);
        @(negedge clk);
        #1;
        n_tests++; if (bus.mem_we !== 1'b0 || bus.mode_leds !== 3'b010) begin
            n_fail++; $display("FAIL b2b_play: got we %b mode %b expected 0 010", bus.mem_we, bus.mode_leds);
        end
        @(posedge clk);
        #1;
        bus.step = 1'b0;
        model_step(4'b1000, 1'b0);
        n_tests++; if (bus.mode_leds !== exp_mode()) begin n_fail++; $display("FAIL b2b_repeat: got %b expected %b", bus.mode_leds, exp_mode()); end
        press(4'b1000);
        n_tests++; if (bus.mode_leds !== 3'b001 || bus.mem_addr !== AW'(1)) begin
            n_fail++; $display("FAIL b2b_next_round: got mode %b addr %0d expected 001 1", bus.mode_leds, bus.mem_addr);
        end
    endtask

    task automatic test_win();
        logic [3:0] p;
        do_reset();
        bus.level = 1'b1;
        for (int round = 1; round <= DEPTH; round++) begin
            p = 4'($urandom_range(1, 15));
            press(p);
            n_tests++; if (obs_we !== 1'b1 || obs_addr !== AW'(round - 1) || obs_wdata !== p) begin
                n_fail++; $display("FAIL win_write r%0d: got we %b addr %0d data %b expected 1 %0d %b", round, obs_we, obs_addr, obs_wdata, round - 1, p);
            end
            for (int i = 0; i < round; i++) begin
                n_tests++; if (bus.pattern_leds !== m_seq[i]) begin
                    n_fail++; $display("FAIL win_play r%0d i%0d: got %b expected %b", round, i, bus.pattern_leds, m_seq[i]);
                end
                press(4'b0000);
            end
            for (int i = 0; i < round; i++) press(m_seq[i]);
            n_tests++; if (bus.mode_leds !== ((round == DEPTH) ? 3'b111 : 3'b001)) begin
                n_fail++; $display("FAIL win_round r%0d: got %b expected %b", round, bus.mode_leds, (round == DEPTH) ? 3'b111 : 3'b001);
            end
        end
        n_tests++; if (m_seq.size() != DEPTH || bus.pattern_leds !== m_seq[0]) begin
            n_fail++; $display("FAIL win_replay: got %b expected %b", bus.pattern_leds, m_seq[0]);
        end
        press(4'b0000);
        n_tests++; if (bus.pattern_leds !== m_seq[1]) begin n_fail++; $display("FAIL win_replay1: got %b expected %b", bus.pattern_leds, m_seq[1]); end
    endtask

    task automatic test_random_games();
        logic [3:0] p;
        for (int g = 0; g < 12; g++) begin
            do_reset();
            bus.level = 1'($urandom_range(0, 1));
            for (int n = 0; n < 40; n++) begin
                if (m_mode == 2 && $urandom_range(0, 99) < 85) p = m_seq[m_cur];
                else if ($urandom_range(0, 1) == 1) p = 4'b0001 << $urandom_range(0, 3);
                else p = 4'($urandom_range(0, 15));
                press(p);
                n_tests++; if (obs_we !== exp_we || (exp_we && (obs_addr !== exp_addr_pre || obs_wdata !== p))) begin
                    n_fail++; $display("FAIL rnd_write g%0d n%0d: got we %b addr %0d expected we %b addr %0d", g, n, obs_we, obs_addr, exp_we, exp_addr_pre);
                end
                n_tests++; if (bus.mode_leds !== exp_mode() || bus.mem_addr !== exp_addr() || bus.pattern_leds !== exp_pleds(p)) begin
                    n_fail++; $display("FAIL rnd_state g%0d n%0d: got mode %b addr %0d leds %b expected %b %0d %b", g, n,
                        bus.mode_leds, bus.mem_addr, bus.pattern_leds, exp_mode(), exp_addr(), exp_pleds(p));
                end
            end
        end
    endtask

    task automatic test_autoplay();
        int c;
        do_reset();
        bus.level = 1'b0;
        press(4'b0001);
        c = 0;
        while (c < 20 && bus.mode_leds !== 3'b100) begin
            @(negedge clk);
            c++;
        end
        n_tests++; if (bus.mode_leds !== 3'b100) begin n_fail++; $display("FAIL auto_first_timeout: got %b expected 100", bus.mode_leds); end
        press(4'b0001);
        n_tests++; if (bus.mode_leds !== 3'b001) begin n_fail++; $display("FAIL auto_repeat_ok: got %b expected 001", bus.mode_leds); end
        press(4'b0010);
        for (int k = 0; k < 2 * PLAY_TICKS; k++) begin
            @(negedge clk);
            n_tests++; if (bus.mode_leds !== 3'b010 || bus.pattern_leds !== ((k < PLAY_TICKS) ? 4'b0001 : 4'b0010)) begin
                n_fail++; $display("FAIL auto_play k%0d: got mode %b leds %b expected 010 %b", k, bus.mode_leds, bus.pattern_leds,
                    (k < PLAY_TICKS) ? 4'b0001 : 4'b0010);
            end
        end
        @(negedge clk);
        n_tests++; if (bus.mode_leds !== 3'b100) begin n_fail++; $display("FAIL auto_to_repeat: got %b expected 100", bus.mode_leds); end
    endtask

    initial begin
        bus.step    = 1'b0;
        bus.level   = 1'b0;
        bus.pattern = 4'b0000;
        model_reset();
        test_reset();
`ifdef SIMON_AUTOPLAY_EN
        test_autoplay();
`else
        test_input_legality();
        test_playback_repeat();
        test_lose();
        test_back_to_back();
        test_win();
        test_random_games();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
